sliced_alu: RTL and testbench

//  Next-generation processor ALU for GB80: parametrised width with a time-sliced adder/subtractor.

---
 rtl/sliced_alu.sv | 201 ++++++++++++++++++++
 tb/tb_sliced_alu.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sliced_alu.sv
// GB80 ALU: parametrised width, adder/subtractor evaluated one slice per cycle,
// start/done handshake with registered result and flags {Z,N,H,C}.
module sliced_alu #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned SLICE_WIDTH  = 4,
  parameter int unsigned OPCODE_WIDTH = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_start,
  input  logic [DATA_WIDTH-1:0]         i_data_A,
  input  logic [DATA_WIDTH-1:0]         i_data_B,
  input  logic [OPCODE_WIDTH-1:0]       i_control,
  input  logic [$clog2(DATA_WIDTH)-1:0] i_bit_sel,
  input  logic [3:0]                    i_flags,
  output logic                          o_busy,
  output logic                          o_done,
  output logic [DATA_WIDTH-1:0]         o_data,
  output logic [3:0]                    o_flags
);

  localparam int unsigned NS    = DATA_WIDTH / SLICE_WIDTH;
  localparam int unsigned CNT_W = (NS > 1) ? $clog2(NS) : 1;
  localparam int unsigned SEL_W = $clog2(DATA_WIDTH);
  localparam int unsigned SW1   = SLICE_WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NS - 1);

  localparam logic [OPCODE_WIDTH-1:0] OP_ADD = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADC = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_SBC = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_AND = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_XOR = OPCODE_WIDTH'(5);
  localparam logic [OPCODE_WIDTH-1:0] OP_OR  = OPCODE_WIDTH'(6);
  localparam logic [OPCODE_WIDTH-1:0] OP_CP  = OPCODE_WIDTH'(7);
  localparam logic [OPCODE_WIDTH-1:0] OP_INC = OPCODE_WIDTH'(8);
  localparam logic [OPCODE_WIDTH-1:0] OP_DEC = OPCODE_WIDTH'(9);
  localparam logic [OPCODE_WIDTH-1:0] OP_RL  = OPCODE_WIDTH'(10);
  localparam logic [OPCODE_WIDTH-1:0] OP_RR  = OPCODE_WIDTH'(11);
  localparam logic [OPCODE_WIDTH-1:0] OP_SLA = OPCODE_WIDTH'(12);
  localparam logic [OPCODE_WIDTH-1:0] OP_SRA = OPCODE_WIDTH'(13);
  localparam logic [OPCODE_WIDTH-1:0] OP_SRL = OPCODE_WIDTH'(14);

  typedef enum logic {IDLE, EXEC} state_t;

  state_t                    state_q, state_d;
  logic [DATA_WIDTH-1:0]     a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [OPCODE_WIDTH-1:0]   op_q, op_d;
  logic [SEL_W-1:0]          sel_q, sel_d;
  logic [3:0]                flg_q, flg_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      carry_q, carry_d, h_q, h_d;
  logic                      busy_d, done_d;
  logic [DATA_WIDTH-1:0]     data_d;
  logic [3:0]                flags_d;

  logic                      sub, arith, cin0, cin, cout, h_now, last;
  logic                      z_f, n_f, h_f, c_f;
  logic [DATA_WIDTH-1:0]     b_full, b_eff, acc_new, res, slice_mask;
  logic [SLICE_WIDTH-1:0]    a_sl, b_sl;
  logic [SW1-1:0]            sum;
  logic [4:0]                lo;
  logic [31:0]               shamt;
  logic [3:0]                flags_new;

  // Slice datapath: subtraction is A + ~B + 1, so the chained bit is an inverted borrow.
  always_comb begin
    sub  = 1'b0;
    cin0 = 1'b0;
    case (op_q)
      OP_ADC:                begin cin0 = flg_q[0]; end
      OP_SUB, OP_CP, OP_DEC: begin sub = 1'b1; cin0 = 1'b1; end
      OP_SBC:                begin sub = 1'b1; cin0 = ~flg_q[0]; end
      default: ;
    endcase
    arith      = (op_q inside {OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_CP, OP_INC, OP_DEC});
    b_full     = (op_q == OP_INC || op_q == OP_DEC) ? DATA_WIDTH'(1) : b_q;
    b_eff      = sub ? ~b_full : b_full;
    cin        = (cnt_q == '0) ? cin0 : carry_q;
    shamt      = SLICE_WIDTH * 32'(cnt_q);
    a_sl       = SLICE_WIDTH'(a_q >> shamt);
    b_sl       = SLICE_WIDTH'(b_eff >> shamt);
    sum        = SW1'(a_sl) + SW1'(b_sl) + SW1'(cin);
    lo         = 5'(a_sl[3:0]) + 5'(b_sl[3:0]) + 5'(cin);
    cout       = sum[SLICE_WIDTH];
    h_now      = (cnt_q == '0) ? lo[4] : h_q;
    slice_mask = DATA_WIDTH'({SLICE_WIDTH{1'b1}}) << shamt;
    acc_new    = (acc_q & ~slice_mask) | ((DATA_WIDTH'(sum[SLICE_WIDTH-1:0])) << shamt);
    last       = !arith || (cnt_q == LAST);
  end

  // Final result and flags; only meaningful on the last EXEC cycle.
  always_comb begin
    res = acc_new;
    n_f = 1'b0;
    h_f = 1'b0;
    c_f = flg_q[0];
    case (op_q)
      OP_ADD, OP_ADC: begin h_f = h_now; c_f = cout; end
      OP_SUB, OP_SBC: begin n_f = 1'b1; h_f = ~h_now; c_f = ~cout; end
      OP_CP:          begin res = a_q; n_f = 1'b1; h_f = ~h_now; c_f = ~cout; end
      OP_INC:         begin h_f = h_now; end
      OP_DEC:         begin n_f = 1'b1; h_f = ~h_now; end
      OP_AND:         begin res = a_q & b_q; h_f = 1'b1; c_f = 1'b0; end
      OP_XOR:         begin res = a_q ^ b_q; c_f = 1'b0; end
      OP_OR:          begin res = a_q | b_q; c_f = 1'b0; end
      OP_RL:          begin res = {a_q[DATA_WIDTH-2:0], flg_q[0]}; c_f = a_q[DATA_WIDTH-1]; end
      OP_RR:          begin res = {flg_q[0], a_q[DATA_WIDTH-1:1]}; c_f = a_q[0]; end
      OP_SLA:         begin res = {a_q[DATA_WIDTH-2:0], 1'b0}; c_f = a_q[DATA_WIDTH-1]; end
      OP_SRA:         begin res = {a_q[DATA_WIDTH-1], a_q[DATA_WIDTH-1:1]}; c_f = a_q[0]; end
      OP_SRL:         begin res = {1'b0, a_q[DATA_WIDTH-1:1]}; c_f = a_q[0]; end
      default:        begin res = a_q; h_f = 1'b1; end
    endcase
    if (op_q == OP_CP)       z_f = (acc_new == '0);
    else if (op_q == 4'hF)   z_f = ~a_q[sel_q];
    else                     z_f = (res == '0);
    flags_new = {z_f, n_f, h_f, c_f};
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    sel_d   = sel_q;
    flg_d   = flg_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    h_d     = h_q;
    acc_d   = acc_q;
    busy_d  = o_busy;
    done_d  = 1'b0;
    data_d  = o_data;
    flags_d = o_flags;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          a_d     = i_data_A;
          b_d     = i_data_B;
          op_d    = i_control;
          sel_d   = i_bit_sel;
          flg_d   = i_flags;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        carry_d = cout;
        h_d     = h_now;
        acc_d   = acc_new;
        if (last) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          data_d  = res;
          flags_d = flags_new;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      sel_q   <= '0;
      flg_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      h_q     <= 1'b0;
      acc_q   <= '0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_data  <= '0;
      o_flags <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      sel_q   <= sel_d;
      flg_q   <= flg_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      h_q     <= h_d;
      acc_q   <= acc_d;
      o_busy  <= busy_d;
      o_done  <= done_d;
      o_data  <= data_d;
      o_flags <= flags_d;
    end
  end

endmodule

// File: tb/tb_sliced_alu.sv
// Scoreboard bench for sliced_alu: 8-bit instance for the op set, 16-bit instance for slicing depth.
module tb_sliced_alu;

  logic clk = 1'b0;
  logic rst_n;

  logic       start8, busy8, done8;
  logic [7:0] a8, b8, data8;
  logic [3:0] op8, fl8, flags8;
  logic [2:0] sel8;

  logic        start16, busy16, done16;
  logic [15:0] a16, b16, data16;
  logic [3:0]  op16, fl16, flags16;
  logic [3:0]  sel16;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  flags;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];
  exp_t e8, e16;

  sliced_alu #(.DATA_WIDTH(8), .SLICE_WIDTH(4), .OPCODE_WIDTH(4)) u_alu8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start8),
    .i_data_A(a8), .i_data_B(b8), .i_control(op8), .i_bit_sel(sel8), .i_flags(fl8),
    .o_busy(busy8), .o_done(done8), .o_data(data8), .o_flags(flags8)
  );

  sliced_alu #(.DATA_WIDTH(16), .SLICE_WIDTH(4), .OPCODE_WIDTH(4)) u_alu16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start16),
    .i_data_A(a16), .i_data_B(b16), .i_control(op16), .i_bit_sel(sel16), .i_flags(fl16),
    .o_busy(busy16), .o_done(done16), .o_data(data16), .o_flags(flags16)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Result monitors: every o_done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done8 === 1'b1) begin
      if (q8.size() == 0) begin
        chk("done8_unexpected", 32'(done8), 32'd0);
      end else begin
        e8 = q8.pop_front();
        chk("data8", 32'(data8), 32'(e8.data));
        chk("flags8", 32'(flags8), 32'(e8.flags));
        chk("latency8", 32'(cyc - e8.acc), 32'(e8.lat));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && done16 === 1'b1) begin
      if (q16.size() == 0) begin
        chk("done16_unexpected", 32'(done16), 32'd0);
      end else begin
        e16 = q16.pop_front();
        chk("data16", 32'(data16), 32'(e16.data));
        chk("flags16", 32'(flags16), 32'(e16.flags));
        chk("latency16", 32'(cyc - e16.acc), 32'(e16.lat));
      end
    end
  end

  task automatic issue8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] sel, input logic [3:0] fl,
                        input logic [7:0] ed, input logic [3:0] ef, input int lat);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (busy8 !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("accept8_timeout", 32'(busy8), 32'd0);
    op8 = op; a8 = a; b8 = b; sel8 = sel; fl8 = fl; start8 = 1'b1;
    @(posedge clk);
    #1;
    e.data = 16'(ed); e.flags = ef; e.lat = lat; e.acc = cyc;
    q8.push_back(e);
    start8 = 1'b0;
  endtask

  task automatic issue16(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] fl, input logic [15:0] ed, input logic [3:0] ef,
                         input int lat);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (busy16 !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("accept16_timeout", 32'(busy16), 32'd0);
    op16 = op; a16 = a; b16 = b; sel16 = 4'd0; fl16 = fl; start16 = 1'b1;
    @(posedge clk);
    #1;
    e.data = ed; e.flags = ef; e.lat = lat; e.acc = cyc;
    q16.push_back(e);
    start16 = 1'b0;
  endtask

  // Wait for outstanding results, then idle a few cycles so stray o_done pulses surface.
  task automatic drain();
    int n;
    n = 0;
    while ((q8.size() != 0 || q16.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 32'(q8.size() + q16.size()), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; op8 = '0; sel8 = '0; fl8 = '0;
    start16 = 1'b0; a16 = '0; b16 = '0; op16 = '0; sel16 = '0; fl16 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_data", 32'(data8), 32'd0);
    chk("rst_flags", 32'(flags8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // op, A, B, bit_sel, flags_in, expected data, expected flags {Z,N,H,C}, latency
    issue8(4'h0, 8'h3A, 8'hC6, 3'd0, 4'b0000, 8'h00, 4'b1011, 2);
    issue8(4'h1, 8'h0F, 8'h00, 3'd0, 4'b0001, 8'h10, 4'b0010, 2);
    issue8(4'h2, 8'h00, 8'h01, 3'd0, 4'b0000, 8'hFF, 4'b0111, 2);
    issue8(4'h3, 8'h10, 8'h01, 3'd0, 4'b0001, 8'h0E, 4'b0110, 2);
    issue8(4'h7, 8'h05, 8'h05, 3'd0, 4'b0000, 8'h05, 4'b1100, 2);
    issue8(4'h8, 8'hFF, 8'h00, 3'd0, 4'b0000, 8'h00, 4'b1010, 2);
    issue8(4'h9, 8'h01, 8'h00, 3'd0, 4'b0001, 8'h00, 4'b1101, 2);
    issue8(4'h4, 8'hF0, 8'h3C, 3'd0, 4'b0001, 8'h30, 4'b0010, 1);
    issue8(4'h5, 8'h5A, 8'h5A, 3'd0, 4'b0001, 8'h00, 4'b1000, 1);
    issue8(4'h6, 8'h00, 8'h00, 3'd0, 4'b0001, 8'h00, 4'b1000, 1);
    issue8(4'hD, 8'h81, 8'h00, 3'd0, 4'b0000, 8'hC0, 4'b0001, 1);
    issue8(4'hA, 8'h80, 8'h00, 3'd0, 4'b0000, 8'h00, 4'b1001, 1);
    issue8(4'hB, 8'h01, 8'h00, 3'd0, 4'b0001, 8'h80, 4'b0001, 1);
    issue8(4'hC, 8'h40, 8'h00, 3'd0, 4'b0001, 8'h80, 4'b0000, 1);
    issue8(4'hE, 8'h01, 8'h00, 3'd0, 4'b0000, 8'h00, 4'b1001, 1);
    issue8(4'hF, 8'h01, 8'h00, 3'd0, 4'b0000, 8'h01, 4'b0010, 1);
    drain();

    // A start pulse while busy must not disturb or duplicate the in-flight ADD.
    issue8(4'h0, 8'h01, 8'h02, 3'd0, 4'b0000, 8'h03, 4'b0000, 2);
    @(negedge clk);
    chk("busy_during_exec", 32'(busy8), 32'd1);
    op8 = 4'h2; a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    drain();

    issue8(4'hF, 8'h7F, 8'h00, 3'd7, 4'b0001, 8'h7F, 4'b1011, 1);
    drain();

    // Reset in the middle of an ADD: outputs clear and no o_done follows.
    @(negedge clk);
    op8 = 4'h0; a8 = 8'h3A; b8 = 8'hC6; start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    @(posedge clk);
    #1;
    chk("busy_before_abort", 32'(busy8), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy8), 32'd0);
    chk("abort_done", 32'(done8), 32'd0);
    chk("abort_data", 32'(data8), 32'd0);
    chk("abort_flags", 32'(flags8), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    issue16(4'h0, 16'h00FF, 16'h0001, 4'b0000, 16'h0100, 4'b0010, 4);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
